// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, FSM state encoding and a
// single-cycle reference computation used by the execute unit.
package alu_pkg;

  localparam int XLEN = 32;

  // {inst30, funct3} codes, shared with the ALU control decoder
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  // Shifts are recognised by funct3 alone; inst30 only picks SRL vs SRA
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op[2:0] == ALU_SLL[2:0]) || (op[2:0] == ALU_SRL[2:0]);
  endfunction

  // One-cycle result; bit 3 only matters for ADD/SUB and SRL/SRA
  function automatic logic [XLEN-1:0] alu_compute(input logic [3:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op[2:0])
      ALU_ADD[2:0]:  r = op[3] ? (a - b) : (a + b);
      ALU_SLL[2:0]:  r = a << b[4:0];
      ALU_SLT[2:0]:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU[2:0]: r = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR[2:0]:  r = a ^ b;
      ALU_SRL[2:0]:  r = op[3] ? ($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      ALU_OR[2:0]:   r = a | b;
      default:       r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational partial shifter: moves the accumulator by 0..2^AMT_W-1
// bit positions per call, left or right, with optional sign fill.
module alu_shift_step #(
  parameter int XLEN  = 32,
  parameter int AMT_W = 4
) (
  input  logic [XLEN-1:0]  data,
  input  logic [AMT_W-1:0] amt,
  input  logic             left,
  input  logic             arith,
  output logic [XLEN-1:0]  shifted
);

  // Select direction and fill; arith only matters for right shifts
  always_comb begin
    if (left) begin
      shifted = data << amt;
    end else if (arith) begin
      shifted = $signed(data) >>> amt;
    end else begin
      shifted = data >> amt;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU. Logic/arith ops finish in one cycle; shifts walk the
// accumulator SHIFT_STEP bits per cycle. Valid/ready on both sides lets the
// pipeline stall, and DONE can hand off and accept in the same cycle.
module alu_exec_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            ltu
);

  import alu_pkg::*;

  alu_state_t      state;
  alu_state_t      state_next;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] comb_result;
  logic [4:0]      remaining;
  logic [4:0]      step_amt;
  logic [4:0]      remaining_next;
  logic            shift_left;
  logic            shift_arith;
  logic            accept;
  logic            start_shift;

  assign accept         = in_valid && in_ready;
  assign start_shift    = is_shift_op(alu_op) && (op_b[4:0] != 5'd0);
  assign step_amt       = (remaining < 5'(SHIFT_STEP)) ? remaining : 5'(SHIFT_STEP);
  assign remaining_next = remaining - step_amt;
  assign comb_result    = alu_compute(alu_op, op_a, op_b);

  alu_shift_step #(
    .XLEN  (XLEN),
    .AMT_W (4)
  ) u_shift_step (
    .data    (acc),
    .amt     (step_amt[3:0]),
    .left    (shift_left),
    .arith   (shift_arith),
    .shifted (shifted)
  );

  // State register; reset abandons any shift in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: DONE hands off and may immediately start the next op
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = start_shift ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (remaining_next == 5'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_next = start_shift ? SHIFT : DONE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs; out_valid comes from state only
  always_comb begin
    out_valid = (state == DONE);
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  end

  // Datapath: capture on accept, iterate shifts, publish when count hits zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result      <= '0;
      zero        <= 1'b0;
      lt          <= 1'b0;
      ltu         <= 1'b0;
      acc         <= '0;
      remaining   <= '0;
      shift_left  <= 1'b0;
      shift_arith <= 1'b0;
    end else if (accept) begin
      lt  <= $signed(op_a) < $signed(op_b);
      ltu <= op_a < op_b;
      if (start_shift) begin
        acc         <= op_a;
        remaining   <= op_b[4:0];
        shift_left  <= (alu_op[2:0] == ALU_SLL[2:0]);
        shift_arith <= alu_op[3];
      end else begin
        result <= comb_result;
        zero   <= (comb_result == '0);
      end
    end else if (state == SHIFT) begin
      acc       <= shifted;
      remaining <= remaining_next;
      if (remaining_next == 5'd0) begin
        result <= shifted;
        zero   <= (shifted == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued when an
// op is accepted and popped when the unit hands a result downstream.
module tb_alu_exec_unit;

  import alu_pkg::*;

  localparam int SHIFT_STEP = 1;

  typedef struct {
    logic [31:0] res;
    logic        zf;
    logic        ltf;
    logic        ltuf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        lt;
  logic        ltu;

  exp_t sb[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(
    .XLEN       (32),
    .SHIFT_STEP (SHIFT_STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .lt        (lt),
    .ltu       (ltu)
  );

  // Bit-serial reference model, decoded on the full 4-bit code
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] r;
    int sh;
    sh = int'(b[4:0]);
    r = a;
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0001, 4'b1001: for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0};
      4'b0010, 4'b1010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011, 4'b1011: r = (a < b) ? 32'd1 : 32'd0;
      4'b0100, 4'b1100: r = a ^ b;
      4'b0101: for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]};
      4'b1101: for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
      4'b0110, 4'b1110: r = a | b;
      default: r = a & b;
    endcase
    e.res  = r;
    e.zf   = (r == 32'd0);
    e.ltf  = ($signed(a) < $signed(b));
    e.ltuf = (a < b);
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    alu_op = op;
    op_a = a;
    op_b = b;
    for (int i = 0; i < 200 && !acc; i++) begin
      #1;
      acc = in_ready;
      if (acc) sb.push_back(model(op, a, b));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic wait_out(output int cyc, output int low);
    cyc = 0;
    low = 0;
    while (!out_valid && cyc < 100) begin
      if (!in_ready) low++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!out_valid) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL out_valid_timeout: got out_valid=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic pop_expect(output exp_t e);
    e.res = '0; e.zf = 1'b0; e.ltf = 1'b0; e.ltuf = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL scoreboard_underflow: got result %h expected none pending", result);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_compared++; if (result !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
    n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_compared++; if ({zero, lt, ltu} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL reset_flags: got %b expected 000", {zero, lt, ltu}); end
    @(posedge clk);
    #1;
    n_compared++; if ({in_ready, out_valid} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL idle_after_reset: got %b expected 10", {in_ready, out_valid}); end
  endtask

  task automatic test_add_sub();
    exp_t e;
    int cyc, low;
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    wait_out(cyc, low);
    pop_expect(e);
    n_compared++; if (cyc !== 0) begin n_mismatched++; $display("[TB] FAIL add_latency: got %0d expected 1", cyc + 1); end
    n_compared++; if (result !== e.res) begin n_mismatched++; $display("[TB] FAIL add_result: got %h expected %h", result, e.res); end
    n_compared++; if ({zero, lt, ltu} !== {e.zf, e.ltf, e.ltuf}) begin n_mismatched++; $display("[TB] FAIL add_flags: got %b expected %b", {zero, lt, ltu}, {e.zf, e.ltf, e.ltuf}); end
    @(posedge clk); #1;
    issue(ALU_SUB, 32'd5, 32'd5);
    wait_out(cyc, low);
    pop_expect(e);
    n_compared++; if (result !== e.res) begin n_mismatched++; $display("[TB] FAIL sub_result: got %h expected %h", result, e.res); end
    n_compared++; if (zero !== e.zf) begin n_mismatched++; $display("[TB] FAIL sub_zero: got %b expected %b", zero, e.zf); end
    @(posedge clk); #1;
  endtask

  task automatic test_slt();
    exp_t e;
    int cyc, low;
    logic [3:0] ops [3];
    ops[0] = ALU_SLT; ops[1] = ALU_SLTU; ops[2] = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 32'hFFFF_FFFF, 32'd1);
      wait_out(cyc, low);
      pop_expect(e);
      n_compared++; if (result !== e.res) begin n_mismatched++; $display("[TB] FAIL slt_result op=%b: got %h expected %h", ops[i], result, e.res); end
      n_compared++; if ({lt, ltu} !== {e.ltf, e.ltuf}) begin n_mismatched++; $display("[TB] FAIL slt_flags op=%b: got %b expected %b", ops[i], {lt, ltu}, {e.ltf, e.ltuf}); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_shift();
    exp_t e;
    int cyc, low;
    int exp_lat;
    exp_lat = 1 + (31 + SHIFT_STEP - 1) / SHIFT_STEP;
    issue(ALU_SRA, 32'h8000_0000, 32'd31);
    wait_out(cyc, low);
    pop_expect(e);
    n_compared++; if (cyc + 1 !== exp_lat) begin n_mismatched++; $display("[TB] FAIL sra_latency: got %0d expected %0d", cyc + 1, exp_lat); end
    n_compared++; if (low !== exp_lat - 1) begin n_mismatched++; $display("[TB] FAIL sra_in_ready_low: got %0d expected %0d", low, exp_lat - 1); end
    n_compared++; if (result !== e.res) begin n_mismatched++; $display("[TB] FAIL sra_result: got %h expected %h", result, e.res); end
    @(posedge clk); #1;
    issue(ALU_SLL, 32'h1234_5678, 32'h0000_0020);
    wait_out(cyc, low);
    pop_expect(e);
    n_compared++; if (cyc !== 0) begin n_mismatched++; $display("[TB] FAIL sll0_latency: got %0d expected 1", cyc + 1); end
    n_compared++; if (result !== e.res) begin n_mismatched++; $display("[TB] FAIL sll0_result: got %h expected %h", result, e.res); end
    @(posedge clk); #1;
    issue(ALU_SLL, 32'h8000_0F01, 32'd7);
    wait_out(cyc, low);
    pop_expect(e);
    n_compared++; if (result !== e.res) begin n_mismatched++; $display("[TB] FAIL sll7_result: got %h expected %h", result, e.res); end
    @(posedge clk); #1;
    issue(ALU_SRL, 32'h8000_00F0, 32'd3);
    wait_out(cyc, low);
    pop_expect(e);
    n_compared++; if (result !== e.res) begin n_mismatched++; $display("[TB] FAIL srl3_result: got %h expected %h", result, e.res); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    exp_t e;
    int cyc, low;
    out_ready = 1'b0;
    issue(ALU_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    wait_out(cyc, low);
    pop_expect(e);
    for (int i = 0; i < 5; i++) begin
      n_compared++; if ({out_valid, result} !== {1'b1, e.res}) begin n_mismatched++; $display("[TB] FAIL hold_cycle%0d: got v=%b %h expected v=1 %h", i, out_valid, result, e.res); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    alu_op = ALU_OR;
    op_a = 32'h0F00_0000;
    op_b = 32'h0000_00F0;
    #1;
    n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_in_ready: got %b expected 1", in_ready); end
    if (in_ready) sb.push_back(model(alu_op, op_a, op_b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    pop_expect(e);
    n_compared++; if ({out_valid, result} !== {1'b1, e.res}) begin n_mismatched++; $display("[TB] FAIL b2b_or: got v=%b %h expected v=1 %h", out_valid, result, e.res); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [3:0]  o;
    logic [31:0] a, b;
    bit have;
    int sent, got, guard;
    localparam int N = 40;
    have = 0; sent = 0; got = 0; guard = 0;
    o = '0; a = '0; b = '0;
    while (got < N && guard < 5000) begin
      out_ready = ($urandom_range(3) != 0);
      if (!have && sent < N) begin
        o = 4'($urandom);
        a = $urandom;
        b = $urandom;
        have = 1;
      end
      in_valid = have;
      alu_op = o;
      op_a = a;
      op_b = b;
      #1;
      if (out_valid && out_ready) begin
        pop_expect(e);
        n_compared++; if ({result, zero, lt, ltu} !== {e.res, e.zf, e.ltf, e.ltuf}) begin n_mismatched++; $display("[TB] FAIL stream_item%0d: got %h/%b expected %h/%b", got, result, {zero, lt, ltu}, e.res, {e.zf, e.ltf, e.ltuf}); end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(o, a, b));
        sent++;
        have = 0;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_compared++; if (got !== N) begin n_mismatched++; $display("[TB] FAIL stream_count: got %0d expected %0d", got, N); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    int spurious;
    spurious = 0;
    issue(ALU_SRL, 32'hFFFF_0000, 32'd20);
    for (int i = 0; i < 9; i++) begin
      if (out_valid) spurious++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    n_compared++; if ({out_valid, in_ready} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL midrst_handshake: got %b expected 01", {out_valid, in_ready}); end
    n_compared++; if (result !== 32'd0) begin n_mismatched++; $display("[TB] FAIL midrst_result: got %h expected 0", result); end
    n_compared++; if ({zero, lt, ltu} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL midrst_flags: got %b expected 000", {zero, lt, ltu}); end
    for (int i = 0; i < 30; i++) begin
      if (out_valid) spurious++;
      @(posedge clk); #1;
    end
    n_compared++; if (spurious !== 0) begin n_mismatched++; $display("[TB] FAIL midrst_spurious: got %0d expected 0", spurious); end
  endtask

  // Run every scenario in order, then report
  initial begin
    $display("[TB] starting alu_exec_unit bench");
    test_reset();
    test_add_sub();
    test_slt();
    test_shift();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
